// File: rtl/cordic_pkg.sv
// Shared types and constant helpers for the iterative rotation-mode CORDIC engine.
// Angles are radians scaled by 2^FRAC.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  // Reference atan(2^-i) in Q30, truncated; entries from i=10 on are 2^(30-i)-1.
  function automatic logic [63:0] atan_q30(input int unsigned idx);
    logic [63:0] v;
    v = 64'd0;
    case (idx)
      32'd0:   v = 64'h3243F6A8;
      32'd1:   v = 64'h1DAC6705;
      32'd2:   v = 64'h0FADBAFC;
      32'd3:   v = 64'h07F56EA6;
      32'd4:   v = 64'h03FEAB76;
      32'd5:   v = 64'h01FFD55B;
      32'd6:   v = 64'h00FFFAAA;
      32'd7:   v = 64'h007FFF55;
      32'd8:   v = 64'h003FFFEA;
      32'd9:   v = 64'h001FFFFD;
      default: begin
        if (idx <= 32'd30) v = (64'd1 << (32'd30 - idx)) - 64'd1;
        else               v = 64'd0;
      end
    endcase
    return v;
  endfunction

  // ATAN[i] rounded to FRAC fractional bits (FRAC up to 30 is exact to the table).
  function automatic logic [63:0] atan_entry(input int unsigned idx, input int unsigned frac);
    logic [63:0] q30;
    q30 = atan_q30(idx);
    if (frac >= 32'd30) return q30 << (frac - 32'd30);
    else                return (q30 + (64'd1 << (32'd29 - frac))) >> (32'd30 - frac);
  endfunction

  function automatic longint k_q(input int frac);
    return longint'(0.6072529 * (2.0 ** frac));
  endfunction

endpackage

// File: rtl/cordic_add_sub.sv
// Wrapping add/subtract stage; a_s=1 selects a-b, a_s=0 selects a+b.
module cordic_add_sub #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         a_s,
  output logic [N-1:0] y
);

  // Select add or subtract, result wraps mod 2^N
  always_comb begin
    if (a_s) y = a - b;
    else     y = a + b;
  end

endmodule

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent table: iteration index -> round(atan(2^-i) * 2^FRAC).
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int N    = 32,
  parameter int FRAC = 16,
  parameter int CW   = 4
) (
  input  logic [CW-1:0] idx,
  output logic [N-1:0]  atan
);

  // Table lookup for the current micro-rotation
  always_comb begin
    atan = N'(atan_entry(32'(idx), FRAC));
  end

endmodule

// File: rtl/cordic_rot_engine.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock, valid/ready on both sides.
// Define CORDIC_GAIN_COMP_EN to add a gain-compensation cycle (multiply by K) before DONE.
module cordic_rot_engine
  import cordic_pkg::*;
#(
  parameter int N    = 32,
  parameter int FRAC = 16,
  parameter int ITER = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  input  logic [N-1:0] z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] x_out,
  output logic [N-1:0] y_out,
  output logic [N-1:0] z_out
);

  localparam int            CW   = cnt_width(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t              state_r;
  logic [CW-1:0]       i_r;
  logic signed [N-1:0] x_r, y_r, z_r;
  logic                in_ready_r, out_valid_r;
  logic [N-1:0]        x_out_r, y_out_r, z_out_r;

  logic                d_s;
  logic signed [N-1:0] y_shr_s, x_shr_s;
  logic [N-1:0]        atan_s, x_nxt_s, y_nxt_s, z_nxt_s;

  // Rotation direction and arithmetic-shifted cross terms from the current registers
  always_comb begin
    d_s     = ~z_r[N-1];
    y_shr_s = y_r >>> i_r;
    x_shr_s = x_r >>> i_r;
  end

  cordic_atan_lut #(.N(N), .FRAC(FRAC), .CW(CW)) u_atan_lut (
    .idx (i_r),
    .atan(atan_s)
  );

  cordic_add_sub #(.N(N)) u_add_sub_x (.a(x_r), .b(y_shr_s), .a_s(d_s),  .y(x_nxt_s));
  cordic_add_sub #(.N(N)) u_add_sub_y (.a(y_r), .b(x_shr_s), .a_s(~d_s), .y(y_nxt_s));
  cordic_add_sub #(.N(N)) u_add_sub_z (.a(z_r), .b(atan_s),  .a_s(d_s),  .y(z_nxt_s));

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [2*N-1:0] K_S = (2*N)'(k_q(FRAC));
  logic signed [2*N-1:0] x_prod_s, y_prod_s;

  // Full-width gain-compensation products; result keeps bits [N+FRAC-1:FRAC]
  always_comb begin
    x_prod_s = (2*N)'(x_r) * K_S;
    y_prod_s = (2*N)'(y_r) * K_S;
  end
`endif

  // Control FSM, iteration datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      i_r         <= '0;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      x_out_r     <= '0;
      y_out_r     <= '0;
      z_out_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            x_r        <= x_in;
            y_r        <= y_in;
            z_r        <= z_in;
            i_r        <= '0;
            in_ready_r <= 1'b0;
            state_r    <= ROT;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ROT: begin
          x_r <= x_nxt_s;
          y_r <= y_nxt_s;
          z_r <= z_nxt_s;
          if (i_r == LAST) begin
            i_r <= '0;
`ifdef CORDIC_GAIN_COMP_EN
            state_r <= COMP;
`else
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            x_out_r     <= x_nxt_s;
            y_out_r     <= y_nxt_s;
            z_out_r     <= z_nxt_s;
`endif
          end else begin
            i_r <= i_r + 1'b1;
          end
        end
        COMP: begin
`ifdef CORDIC_GAIN_COMP_EN
          x_r         <= x_prod_s[N+FRAC-1:FRAC];
          y_r         <= y_prod_s[N+FRAC-1:FRAC];
          x_out_r     <= x_prod_s[N+FRAC-1:FRAC];
          y_out_r     <= y_prod_s[N+FRAC-1:FRAC];
          z_out_r     <= z_r;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
`else
          state_r <= IDLE;
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign x_out     = x_out_r;
  assign y_out     = y_out_r;
  assign z_out     = z_out_r;

endmodule
